// File: rtl/jtcps1_lbuf_pkg.sv
// Shared FSM encoding and default geometry for the CPS1 tilemap line-buffer scan-out.
package jtcps1_lbuf_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StErase = 2'd2;

    localparam logic [7:0]  DefBlank    = 8'hFF;
    localparam int unsigned DefHoffset  = 64;
    localparam int unsigned DefHvisible = 384;

endpackage

// File: rtl/jtcps1_lbuf_dpram.sv
// Two-bank line RAM: port A is the tilemap write port, port B reads and then erases.
module jtcps1_lbuf_dpram #(
    parameter int unsigned AW = 9
) (
    input  logic        clk,
    input  logic        we_a,
    input  logic [AW:0] addr_a,
    input  logic [7:0]  data_a,
    input  logic        re_b,
    input  logic        we_b,
    input  logic [AW:0] addr_b,
    input  logic [7:0]  data_b,
    output logic [7:0]  q_b
);

    localparam int unsigned Depth = 1 << (AW + 1);

    logic [7:0] mem [Depth];
    logic [7:0] q_b_q;

    // Ports A and B always address different banks, so the two writes never collide.
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
        if (re_b) q_b_q <= mem[addr_b];
    end

    assign q_b = q_b_q;

endmodule

// File: rtl/jtcps1_lbuf_scan.sv
// Ping-pong line buffer reader: swaps banks on each line, streams one pixel per pxl_cen and
// erases every location right after reading it.
module jtcps1_lbuf_scan
    import jtcps1_lbuf_pkg::*;
#(
    parameter int unsigned AW       = 9,
    parameter int unsigned HOFFSET  = DefHoffset,
    parameter int unsigned HVISIBLE = DefHvisible,
    parameter logic [7:0]  BLANK    = DefBlank
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          line_start,
    input  logic          fill_done,
    input  logic [AW-1:0] buf_addr,
    input  logic [7:0]    buf_data,
    input  logic          buf_wr,
    output logic          fill_start,
    output logic [7:0]    pxl,
    output logic          pxl_vld,
    output logic          underrun
);

    localparam int unsigned PW = $clog2(HVISIBLE + 1);

    logic [1:0]    state_q, state_d;
    logic          rd_bank_q, rd_bank_d;
    logic          ready_q, ready_d;
    logic          blank_line_q, blank_line_d;
    logic [AW-1:0] hcnt_q, hcnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [7:0]    pxl_q, pxl_d;
    logic          pxl_vld_q, pxl_vld_d;
    logic          fill_start_q, fill_start_d;
    logic          underrun_q, underrun_d;
    logic          rd_en;
    logic          erase;
    logic [7:0]    rd_data;

    assign rd_en = (state_q == StRun) && pxl_cen && !line_start;
    assign erase = (state_q == StErase);

    always_comb begin
        state_d      = state_q;
        rd_bank_d    = rd_bank_q;
        blank_line_d = blank_line_q;
        hcnt_d       = hcnt_q;
        pcnt_d       = pcnt_q;
        pxl_d        = pxl_q;
        pxl_vld_d    = pxl_vld_q;
        fill_start_d = 1'b0;
        underrun_d   = 1'b0;
        // fill_start wins over a coincident fill_done
        ready_d      = fill_start_q ? 1'b0 : (fill_done ? 1'b1 : ready_q);

        case (state_q)
            StRun: begin
                if (pxl_cen) state_d = StErase;
            end
            StErase: begin
                pxl_d     = blank_line_q ? BLANK : rd_data;
                pxl_vld_d = 1'b1;
                hcnt_d    = hcnt_q + AW'(1);
                pcnt_d    = pcnt_q + PW'(1);
                state_d   = (pcnt_q == PW'(HVISIBLE - 1)) ? StIdle : StRun;
            end
            default: begin
                if (pxl_cen) pxl_vld_d = 1'b0;
            end
        endcase

        // A new line overrides the FSM; any erase pending this cycle still lands in the old bank.
        if (line_start) begin
            rd_bank_d    = ~rd_bank_q;
            blank_line_d = ~ready_q;
            underrun_d   = ~ready_q;
            fill_start_d = 1'b1;
            hcnt_d       = AW'(HOFFSET);
            pcnt_d       = '0;
            state_d      = StRun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rd_bank_q    <= 1'b0;
            ready_q      <= 1'b0;
            blank_line_q <= 1'b0;
            hcnt_q       <= '0;
            pcnt_q       <= '0;
            pxl_q        <= BLANK;
            pxl_vld_q    <= 1'b0;
            fill_start_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_bank_q    <= rd_bank_d;
            ready_q      <= ready_d;
            blank_line_q <= blank_line_d;
            hcnt_q       <= hcnt_d;
            pcnt_q       <= pcnt_d;
            pxl_q        <= pxl_d;
            pxl_vld_q    <= pxl_vld_d;
            fill_start_q <= fill_start_d;
            underrun_q   <= underrun_d;
        end
    end

    jtcps1_lbuf_dpram #(
        .AW (AW)
    ) u_ram (
        .clk    (clk),
        .we_a   (buf_wr),
        .addr_a ({~rd_bank_q, buf_addr}),
        .data_a (buf_data),
        .re_b   (rd_en),
        .we_b   (erase),
        .addr_b ({rd_bank_q, hcnt_q}),
        .data_b (BLANK),
        .q_b    (rd_data)
    );

    assign fill_start = fill_start_q;
    assign pxl        = pxl_q;
    assign pxl_vld    = pxl_vld_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_jtcps1_lbuf_scan.sv
// Bench for jtcps1_lbuf_scan: two instances (HOFFSET 64 and 448) against a bank-array model.
module tb_jtcps1_lbuf_scan;

    localparam int unsigned AW    = 9;
    localparam int          NPX   = 384;
    localparam int          Depth = 512;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          pxl_cen    = 1'b0;
    logic          line_start = 1'b0;
    logic          fill_done  = 1'b0;
    logic          buf_wr     = 1'b0;
    logic [AW-1:0] buf_addr   = '0;
    logic [7:0]    buf_data   = '0;

    logic          fill_start [2];
    logic [7:0]    pxl        [2];
    logic          pxl_vld    [2];
    logic          underrun   [2];

    jtcps1_lbuf_scan #(
        .AW       (AW),
        .HOFFSET  (64),
        .HVISIBLE (NPX),
        .BLANK    (8'hFF)
    ) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .pxl_cen    (pxl_cen),
        .line_start (line_start),
        .fill_done  (fill_done),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .buf_wr     (buf_wr),
        .fill_start (fill_start[0]),
        .pxl        (pxl[0]),
        .pxl_vld    (pxl_vld[0]),
        .underrun   (underrun[0])
    );

    jtcps1_lbuf_scan #(
        .AW       (AW),
        .HOFFSET  (448),
        .HVISIBLE (NPX),
        .BLANK    (8'hFF)
    ) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .pxl_cen    (pxl_cen),
        .line_start (line_start),
        .fill_done  (fill_done),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .buf_wr     (buf_wr),
        .fill_start (fill_start[1]),
        .pxl        (pxl[1]),
        .pxl_vld    (pxl_vld[1]),
        .underrun   (underrun[1])
    );

    always #5 clk = ~clk;

    // Reference model: per-instance bank contents, read bank, ready flag, blanking of current line.
    int         off [2] = '{64, 448};
    logic [7:0] mdl [2][2][Depth];
    bit         rd_m;
    bit         ready_m;
    bit         blank_m;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_bank(input bit rnd);
        for (int a = 0; a < Depth; a++) begin
            @(negedge clk);
            buf_wr   = 1'b1;
            buf_addr = AW'(a);
            buf_data = rnd ? 8'($urandom) : 8'(a);
            for (int i = 0; i < 2; i++) mdl[i][rd_m ^ 1'b1][a] = buf_data;
        end
        @(negedge clk);
        buf_wr = 1'b0;
    endtask

    task automatic done_pulse();
        @(negedge clk);
        fill_done = 1'b1;
        ready_m   = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
    endtask

    // abort_idx >= 0 issues a pxl_cen one cycle before line_start so the erase is still pending.
    task automatic start_line(input bit wr_too, input bit done_coinc, input int abort_idx);
        bit exp_under;
        if (abort_idx >= 0) begin
            for (int i = 0; i < 2; i++) mdl[i][rd_m][(off[i] + abort_idx) % Depth] = 8'hFF;
            @(negedge clk);
            pxl_cen = 1'b1;
        end
        @(negedge clk);
        pxl_cen    = 1'b0;
        line_start = 1'b1;
        if (wr_too) begin
            buf_wr   = 1'b1;
            buf_addr = AW'($urandom);
            buf_data = 8'($urandom);
            for (int i = 0; i < 2; i++) mdl[i][rd_m ^ 1'b1][buf_addr] = buf_data;
        end
        exp_under = !ready_m;
        blank_m   = exp_under;
        rd_m      = ~rd_m;
        ready_m   = 1'b0;
        @(negedge clk);
        line_start = 1'b0;
        buf_wr     = 1'b0;
        fill_done  = done_coinc;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("fill_start_hi%0d", i), fill_start[i], 1'b1);
            check_eq($sformatf("underrun%0d", i), underrun[i], exp_under);
        end
        @(negedge clk);
        fill_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("fill_start_lo%0d", i), fill_start[i], 1'b0);
            check_eq($sformatf("underrun_lo%0d", i), underrun[i], 1'b0);
        end
    endtask

    task automatic pixel(input int idx, input bit do_wr, input bit do_done);
        int         a;
        logic [7:0] exp [2];
        for (int i = 0; i < 2; i++) begin
            a          = (off[i] + idx) % Depth;
            exp[i]     = blank_m ? 8'hFF : mdl[i][rd_m][a];
            mdl[i][rd_m][a] = 8'hFF;
        end
        @(negedge clk);
        pxl_cen = 1'b1;
        if (do_wr) begin
            buf_wr   = 1'b1;
            buf_addr = AW'($urandom);
            buf_data = 8'($urandom);
            for (int i = 0; i < 2; i++) mdl[i][rd_m ^ 1'b1][buf_addr] = buf_data;
        end
        if (do_done) begin
            fill_done = 1'b1;
            ready_m   = 1'b1;
        end
        @(negedge clk);
        pxl_cen   = 1'b0;
        buf_wr    = 1'b0;
        fill_done = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("pxl%0d[%0d]", i, idx), pxl[i], exp[i]);
            check_eq($sformatf("vld%0d[%0d]", i, idx), pxl_vld[i], 1'b1);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic run_line(input int from, input int to, input int wr_pct, input int done_at);
        for (int idx = from; idx < to; idx++)
            pixel(idx, $urandom_range(0, 99) < wr_pct, idx == done_at);
    endtask

    task automatic idle_cen();
        @(negedge clk);
        pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check_eq($sformatf("vld_end%0d", i), pxl_vld[i], 1'b0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        bit full;
        bit coinc;
        int done_at;

        rd_m    = 1'b0;
        ready_m = 1'b0;
        blank_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("rst_pxl%0d", i), pxl[i], 8'hFF);
            check_eq($sformatf("rst_vld%0d", i), pxl_vld[i], 1'b0);
            check_eq($sformatf("rst_fill_start%0d", i), fill_start[i], 1'b0);
            check_eq($sformatf("rst_underrun%0d", i), underrun[i], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // First line after reset has no fill: blanked with underrun
        start_line(1'b0, 1'b0, -1);
        run_line(0, NPX, 0, -1);
        idle_cen();

        // Normal line with data = addr[7:0]
        fill_bank(1'b0);
        done_pulse();
        start_line(1'b0, 1'b0, -1);
        run_line(0, NPX, 0, -1);
        idle_cen();

        // Two lines with fill_done but no writes: both banks read back erased
        repeat (2) begin
            done_pulse();
            start_line(1'b0, 1'b0, -1);
            run_line(0, NPX, 0, -1);
            idle_cen();
        end

        // Randomized lines, including a fill_done coincident with fill_start
        for (int k = 0; k < 5; k++) begin
            full    = (k < 2) || ($urandom_range(0, 1) == 1);
            coinc   = (k == 2);
            done_at = (k == 2 || $urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, NPX - 1));
            start_line(1'($urandom_range(0, 1)), coinc, -1);
            if (full) fill_bank(1'b1);
            run_line(0, NPX, 25, done_at);
            idle_cen();
        end

        // Abort at pixel 100 with its erase pending, then read the aborted bank again
        fill_bank(1'b1);
        done_pulse();
        start_line(1'b0, 1'b0, -1);
        run_line(0, 60, 0, -1);
        fill_bank(1'b1);
        done_pulse();
        run_line(60, 100, 0, -1);
        start_line(1'b0, 1'b0, 100);
        run_line(0, NPX, 0, -1);
        idle_cen();
        done_pulse();
        start_line(1'b0, 1'b0, -1);
        run_line(0, NPX, 0, -1);
        idle_cen();

        // Mid-line asynchronous reset
        fill_bank(1'b1);
        done_pulse();
        start_line(1'b0, 1'b0, -1);
        run_line(0, 200, 0, -1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("mrst_pxl%0d", i), pxl[i], 8'hFF);
            check_eq($sformatf("mrst_vld%0d", i), pxl_vld[i], 1'b0);
            check_eq($sformatf("mrst_fill_start%0d", i), fill_start[i], 1'b0);
            check_eq($sformatf("mrst_underrun%0d", i), underrun[i], 1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        rd_m    = 1'b0;
        ready_m = 1'b0;
        start_line(1'b0, 1'b0, -1);
        run_line(0, NPX, 0, -1);
        idle_cen();
        fill_bank(1'b1);
        done_pulse();
        start_line(1'b0, 1'b0, -1);
        run_line(0, NPX, 0, -1);
        idle_cen();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
